// File: rtl/pal_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pal_gen_if
//  Brief    : Valid/ready word stream from the palindrome generator to its sink.
//             With PAL_GEN_ERRINJ_EN defined, the stream also carries out_bad.
//  Revision : 1.0 - initial release
// ============================================================================
interface pal_gen_if #(
  parameter int W = 4
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef PAL_GEN_ERRINJ_EN
  logic         out_bad;
`endif

  modport master (
    output out_valid,
    output out_data,
    output out_last,
`ifdef PAL_GEN_ERRINJ_EN
    output out_bad,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
`ifdef PAL_GEN_ERRINJ_EN
    input  out_bad,
`endif
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/pal_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pal_gen
//  Brief    : Emits every W-bit palindrome once per run, in ascending seed
//             order. Optional macro PAL_GEN_ERRINJ_EN adds bit-0 error injection.
//  Revision : 1.0 - initial release
// ============================================================================
module pal_gen #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         start,
  input  wire logic         abort,
`ifdef PAL_GEN_ERRINJ_EN
  input  wire logic         err_inj,
`endif
  output logic              busy,
  output logic              done,
  output logic [W/2:0]      count,
  pal_gen_if.master         bus
);

  localparam int           c_hw       = W / 2;
  localparam logic [c_hw-1:0] c_seed_max = '1;
  localparam logic [W-1:0] c_bit0     = {{(W-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_hw-1:0] r_seed;
  logic [c_hw-1:0] w_seed_nxt;
  logic [W-1:0]    r_data;
  logic [W-1:0]    w_word_nxt;
  logic            r_last;
  logic [c_hw:0]   r_count;
  logic            w_valid;
  logic            w_xfer;
  logic            w_begin;
  logic            w_advance;
  logic            w_load;
  logic            w_inj;

  assign w_xfer     = w_valid & bus.out_ready;
  assign w_begin    = (r_state == c_st_idle) & start & ~abort;
  assign w_advance  = w_xfer & (r_seed != c_seed_max);
  assign w_load     = w_begin | w_advance;
  assign w_seed_nxt = w_begin ? '0 : r_seed + 1'b1;

  // Mirror each seed bit into both halves of the word.
  generate
    for (genvar gi = 0; gi < c_hw; gi++) begin : g_map
      assign w_word_nxt[gi]       = w_seed_nxt[gi];
      assign w_word_nxt[W-1-gi]   = w_seed_nxt[gi];
    end
  endgenerate

`ifdef PAL_GEN_ERRINJ_EN
  logic r_bad;
  assign w_inj       = err_inj;
  assign bus.out_bad = r_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
    end else if (w_load) begin
      r_bad <= w_inj;
    end
  end
`else
  assign w_inj = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks both start and the final transfer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_begin) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        if (abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_xfer && (r_seed == c_seed_max)) begin
          w_state_nxt = c_st_done;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      c_st_run: begin
        w_valid = 1'b1;
        busy    = 1'b1;
      end
      c_st_done: begin
        busy    = 1'b1;
        done    = 1'b1;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // Word register only moves on a load, so backpressure holds it stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_load) begin
        r_seed <= w_seed_nxt;
        r_data <= w_word_nxt ^ ({W{w_inj}} & c_bit0);
        r_last <= (w_seed_nxt == c_seed_max);
      end else if (w_xfer || (w_valid && abort)) begin
        r_last <= 1'b0;
      end

      if (w_begin) begin
        r_count <= '0;
      end else if (w_xfer) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pal_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pal_gen
//  Brief    : Self-checking bench for pal_gen against an enumerated palindrome list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pal_gen;
  localparam int W = 4;
  localparam int H = W / 2;
  localparam int N = 1 << H;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic [H:0]   count;
`ifdef PAL_GEN_ERRINJ_EN
  logic         err_inj = 1'b0;
`endif

  pal_gen_if #(.W(W)) bus ();

  pal_gen #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
`ifdef PAL_GEN_ERRINJ_EN
    .err_inj (err_inj),
`endif
    .busy    (busy),
    .done    (done),
    .count   (count),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned exp_q[$];

  function automatic bit is_pal(input int unsigned v);
    for (int i = 0; i < W; i++) begin
      if (((v >> i) & 1) != ((v >> (W - 1 - i)) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run: ready from pattern or random, optional abort at a word index,
  // start poked during the run (0 none, 1 random, 2 every cycle).
  task automatic do_run(input int ready_pct, input int abort_at, input bit use_pat,
                        input logic [15:0] pat, input int poke);
    int idx    = 0;
    int cnt    = 0;
    int cycles = 0;
    bit fin    = 1'b0;
    bit r;
    bit ab;
    start = 1'b1;
    bus.out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("first_valid", 32'(bus.out_valid), 1);
    chk("first_busy",  32'(busy), 1);
    chk("first_data",  32'(bus.out_data), exp_q[0]);
    chk("first_count", 32'(count), 0);
    while (!fin && cycles < 200) begin
      if (use_pat) r = (cycles < 16) ? pat[cycles] : 1'b1;
      else         r = ($urandom_range(99) < ready_pct);
      cycles++;
      ab = (idx == abort_at);
      bus.out_ready = r;
      abort = ab;
      start = (poke == 2) || (poke == 1 && $urandom_range(3) == 0);
      step();
      bus.out_ready = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      if (r) begin
        idx++;
        cnt++;
      end
      if (ab) begin
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_done",  32'(done), 0);
        chk("abort_count", 32'(count), cnt);
        fin = 1'b1;
      end else if (idx == N) begin
        chk("end_valid", 32'(bus.out_valid), 0);
        chk("end_done",  32'(done), 1);
        chk("end_last",  32'(bus.out_last), 0);
        chk("end_count", 32'(count), N);
        start = (poke == 2);
        step();
        start = 1'b0;
        chk("idle_done",  32'(done), 0);
        chk("idle_busy",  32'(busy), 0);
        chk("idle_valid", 32'(bus.out_valid), 0);
        fin = 1'b1;
      end else begin
        chk("run_valid", 32'(bus.out_valid), 1);
        chk("run_data",  32'(bus.out_data), exp_q[idx]);
        chk("run_last",  32'(bus.out_last), 32'(idx == N - 1));
        chk("run_done",  32'(done), 0);
        chk("run_count", 32'(count), cnt);
`ifdef PAL_GEN_ERRINJ_EN
        chk("run_bad",   32'(bus.out_bad), 0);
`endif
      end
    end
    chk("run_timeout", 32'(fin), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reference list: all palindromes, ordered by their low-half seed.
    for (int s = 0; s < N; s++) begin
      for (int unsigned v = 0; v < (1 << W); v++) begin
        if (is_pal(v) && (v % N) == s) exp_q.push_back(v);
      end
    end

    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    step();

    // Full run at full throughput, then backpressure on word 1 for 3 cycles
    do_run(0, -1, 1'b1, 16'hFFFF, 0);
    do_run(0, -1, 1'b1, 16'hFFF1, 0);
    // Abort with a transfer on the third word, then a clean restart
    do_run(0, 2, 1'b1, 16'hFFFF, 0);
    // Start held high through a run and its done cycle
    do_run(0, -1, 1'b1, 16'hFFFF, 2);

    // start together with abort in IDLE never begins a run
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy",  32'(busy), 0);
    chk("sa_valid", 32'(bus.out_valid), 0);
    step();
    chk("sa_busy2", 32'(busy), 0);

    // Reset in the middle of a run
    start = 1'b1;
    step();
    start = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data",  32'(bus.out_data), 0);
    chk("mid_rst_last",  32'(bus.out_last), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);

`ifdef PAL_GEN_ERRINJ_EN
    start = 1'b1;
    step();
    start = 1'b0;
    chk("inj_first_bad", 32'(bus.out_bad), 0);
    err_inj = 1'b1;
    bus.out_ready = 1'b1;
    step();
    err_inj = 1'b0;
    bus.out_ready = 1'b0;
    chk("inj_data", 32'(bus.out_data), exp_q[1] ^ 1);
    chk("inj_bad",  32'(bus.out_bad), 1);
    chk("inj_reject", 32'(is_pal(32'(bus.out_data))), 0);
    bus.out_ready = 1'b1;
    step();
    chk("inj_next_data", 32'(bus.out_data), exp_q[2]);
    chk("inj_next_bad",  32'(bus.out_bad), 0);
    step();
    step();
    bus.out_ready = 1'b0;
    chk("inj_done",  32'(done), 1);
    chk("inj_count", 32'(count), N);
    step();
`endif

    // Randomized runs: random ready, random start pokes, occasional abort
    for (int k = 0; k < 8; k++) begin
      do_run($urandom_range(90, 30),
             ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1,
             1'b0, 16'h0000, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
